// File: rtl/timer_pkg.sv
// Shared definitions for the timer peripheral: control-word bit map and decoded view.
// Imported by timer and timer_prescaler (prescaler enabled by TIMER_PRESCALER_EN).
package timer_pkg;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_LOAD     = 1;
  localparam int CTRL_RELOAD   = 2;
  localparam int CTRL_IE       = 3;
  localparam int CTRL_PSEL_LSB = 4;
  localparam int CTRL_PSEL_W   = 3;
  localparam int CTRL_RSVD     = 7;

  typedef struct packed {
    logic                   rsvd;
    logic [CTRL_PSEL_W-1:0] psel;
    logic                   ie;
    logic                   reload;
    logic                   load;
    logic                   en;
  } ctrl_t;

  // Field-by-field decode so the struct layout never silently drifts from the bit map.
  function automatic ctrl_t decode_ctrl(input logic [7:0] raw);
    ctrl_t c;
    c.en     = raw[CTRL_EN];
    c.load   = raw[CTRL_LOAD];
    c.reload = raw[CTRL_RELOAD];
    c.ie     = raw[CTRL_IE];
    c.psel   = raw[CTRL_PSEL_LSB +: CTRL_PSEL_W];
    c.rsvd   = raw[CTRL_RSVD];
    return c;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler producing a one-cycle tick every 2^(psel*PSEL_STEP) enabled cycles.
// Only instantiated when TIMER_PRESCALER_EN is defined.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PSEL_STEP = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clr,
  input  logic [CTRL_PSEL_W-1:0] psel,
  output logic                   tick
);

  localparam int PW = 7 * PSEL_STEP;

  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW:0]   span;
  logic [PW-1:0] limit;

  // '>=' rather than '==' so a PSEL decrease with a larger residual count ticks
  // immediately instead of running all the way round the counter.
  always_comb begin
    span  = (PW+1)'(1) << (psel * PSEL_STEP);
    limit = PW'(span - 1'b1);
    tick  = en & ~clr & (cnt_q >= limit);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer.sv
// Programmable down-counting timer with one-cycle expiry interrupt pulse.
// Define TIMER_PRESCALER_EN to add the PSEL-driven prescaler; otherwise EN ticks every cycle.
module timer
  import timer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PSEL_STEP = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       ctrl,
  input  logic [WIDTH-1:0] set,
  output logic [WIDTH-1:0] read,
  output logic             irq
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  ctrl_t            c;
  logic             tick;
  logic [WIDTH-1:0] count_q, count_d;
  logic             irq_q, irq_d;
  logic             unused_cfg;

  assign c = decode_ctrl(ctrl);

`ifdef TIMER_PRESCALER_EN
  timer_prescaler #(
    .PSEL_STEP (PSEL_STEP)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (c.en),
    .clr   (c.load),
    .psel  (c.psel),
    .tick  (tick)
  );
  assign unused_cfg = c.rsvd;
`else
  assign tick       = c.en;
  assign unused_cfg = ^{c.rsvd, c.psel, PSEL_STEP[0]};
`endif

  // LOAD wins over any tick; irq is a pulse, so it defaults low every cycle.
  always_comb begin
    count_d = count_q;
    irq_d   = 1'b0;
    if (c.load) begin
      count_d = set;
    end else if (tick) begin
      if (count_q > ONE) begin
        count_d = count_q - ONE;
      end else if (count_q == ONE) begin
        irq_d   = c.ie;
        count_d = c.reload ? set : '0;
      end else if (c.reload) begin
        count_d = set;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      irq_q   <= irq_d;
    end
  end

  assign read = count_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: directed scenarios plus randomized traffic against a behavioural model.
module tb_timer;

  localparam logic [7:0] EN     = 8'h01;
  localparam logic [7:0] LOAD   = 8'h02;
  localparam logic [7:0] RELOAD = 8'h04;
  localparam logic [7:0] IE     = 8'h08;
  localparam logic [7:0] PSEL1  = 8'h10;

`ifdef TIMER_PRESCALER_EN
  localparam bit PRESCALE = 1'b1;
`else
  localparam bit PRESCALE = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] ctrl;
  logic [7:0] set;
  logic [7:0] read;
  logic       irq;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [7:0] m_count;
  logic       m_irq;
  int         m_phase;

  timer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (ctrl),
    .set   (set),
    .read  (read),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_count = '0;
    m_irq   = 1'b0;
    m_phase = 0;
  endtask

  // One clock edge of the timer as described behaviourally: the tick period is
  // 2^(3*PSEL) enabled cycles, the count walks down to expiry then reloads or stops.
  task automatic model_step();
    int period;
    period = PRESCALE ? (1 << (3 * int'(ctrl[6:4]))) : 1;
    m_irq  = 1'b0;
    if (ctrl[1]) begin
      m_count = set;
      m_phase = 0;
    end else if (ctrl[0]) begin
      m_phase = m_phase + 1;
      if (m_phase >= period) begin
        m_phase = 0;
        if (m_count > 1) begin
          m_count = m_count - 1;
        end else if (m_count == 1) begin
          m_irq   = ctrl[3];
          m_count = ctrl[2] ? set : 8'd0;
        end else if (ctrl[2]) begin
          m_count = set;
        end
      end
    end
  endtask

  task automatic step(input logic [7:0] c, input logic [7:0] s);
    ctrl = c;
    set  = s;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    ctrl  = 8'h00;
    set   = 8'h00;
    rst_n = 1'b0;
    model_reset();
    #12;
    rst_n = 1'b1;
    total++;
    if (read !== 8'd0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_initial got read=%0d irq=%0b want read=0 irq=0", read, irq);
    end
    step(LOAD, 8'd5);
    step(8'h00, 8'd5);
    total++;
    if (read !== 8'd5) begin
      bad++;
      $display("FAIL reset_preload got read=%0d want 5", read);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (read !== 8'd0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_async got read=%0d irq=%0b want read=0 irq=0", read, irq);
    end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(8'h00, 8'd9);
      total++;
      if (read !== 8'd0 || irq !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold step=%0d got read=%0d irq=%0b want read=0 irq=0", i, read, irq);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [7:0] exp_r [5];
    logic       exp_i [5];
    exp_r = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
    exp_i = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    step(EN | LOAD | IE, 8'd3);
    total++;
    if (read !== 8'd3 || irq !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_load got read=%0d irq=%0b want read=3 irq=0", read, irq);
    end
    for (int i = 0; i < 5; i++) begin
      step(EN | IE, 8'd3);
      total++;
      if (read !== exp_r[i] || irq !== exp_i[i] || read !== m_count || irq !== m_irq) begin
        bad++;
        $display("FAIL oneshot step=%0d got read=%0d irq=%0b want read=%0d irq=%0b",
                 i, read, irq, exp_r[i], exp_i[i]);
      end
    end
  endtask

  task automatic test_reload(input bit ie);
    logic [7:0] c;
    logic [7:0] exp_r;
    logic       exp_i;
    int         n_irq;
    c = EN | RELOAD | (ie ? IE : 8'h00);
    n_irq = 0;
    step(c | LOAD, 8'd4);
    total++;
    if (read !== 8'd4) begin
      bad++;
      $display("FAIL reload_load ie=%0b got read=%0d want 4", ie, read);
    end
    for (int i = 1; i <= 12; i++) begin
      step(c, 8'd4);
      exp_r = 8'(4 - (i % 4));
      exp_i = ie && (i % 4 == 0);
      if (irq === 1'b1) n_irq++;
      total++;
      if (read !== exp_r || irq !== exp_i || read !== m_count || irq !== m_irq) begin
        bad++;
        $display("FAIL reload ie=%0b step=%0d got read=%0d irq=%0b want read=%0d irq=%0b",
                 ie, i, read, irq, exp_r, exp_i);
      end
    end
    total++;
    if (n_irq !== (ie ? 3 : 0)) begin
      bad++;
      $display("FAIL reload_irq_count ie=%0b got %0d want %0d", ie, n_irq, ie ? 3 : 0);
    end
  endtask

  task automatic test_prescaler();
    int first_dec;
    int first_irq;
    int want_dec;
    int want_irq;
    logic [7:0] freeze_val;
    logic [7:0] resume_val;
    want_dec   = PRESCALE ? 8 : 1;
    want_irq   = PRESCALE ? 16 : 2;
    freeze_val = PRESCALE ? 8'd200 : 8'd195;
    resume_val = PRESCALE ? 8'd199 : 8'd192;
    first_dec  = -1;
    first_irq  = -1;
    step(EN | LOAD | IE | PSEL1, 8'd2);
    for (int i = 1; i <= 40 && first_irq < 0; i++) begin
      step(EN | IE | PSEL1, 8'd2);
      if (first_dec < 0 && read === 8'd1) first_dec = i;
      if (irq === 1'b1) first_irq = i;
      total++;
      if (read !== m_count || irq !== m_irq) begin
        bad++;
        $display("FAIL psel_model step=%0d got read=%0d irq=%0b want read=%0d irq=%0b",
                 i, read, irq, m_count, m_irq);
      end
    end
    total++;
    if (first_dec !== want_dec) begin
      bad++;
      $display("FAIL psel_first_dec got cycle=%0d want %0d", first_dec, want_dec);
    end
    total++;
    if (first_irq !== want_irq) begin
      bad++;
      $display("FAIL psel_first_irq got cycle=%0d want %0d (-1 means none within 40)", first_irq, want_irq);
    end
    step(EN | LOAD | PSEL1, 8'd200);
    for (int i = 0; i < 5; i++) step(EN | PSEL1, 8'd200);
    for (int i = 0; i < 10; i++) begin
      step(PSEL1, 8'd17);
      total++;
      if (read !== freeze_val || irq !== 1'b0) begin
        bad++;
        $display("FAIL psel_freeze step=%0d got read=%0d irq=%0b want read=%0d irq=0",
                 i, read, irq, freeze_val);
      end
    end
    for (int i = 0; i < 3; i++) step(EN | PSEL1, 8'd17);
    total++;
    if (read !== resume_val || read !== m_count) begin
      bad++;
      $display("FAIL psel_resume got read=%0d want %0d", read, resume_val);
    end
  endtask

  task automatic test_load_hold();
    logic [7:0] s;
    for (int i = 0; i < 8; i++) begin
      s = 8'($urandom_range(0, 255));
      step(EN | LOAD | RELOAD | IE, s);
      total++;
      if (read !== s || irq !== 1'b0) begin
        bad++;
        $display("FAIL load_hold step=%0d got read=%0d irq=%0b want read=%0d irq=0", i, read, irq, s);
      end
    end
    step(EN | LOAD | RELOAD | IE, 8'd0);
    for (int i = 0; i < 40; i++) begin
      step(EN | RELOAD | IE, 8'd0);
      total++;
      if (read !== 8'd0 || irq !== 1'b0) begin
        bad++;
        $display("FAIL set_zero step=%0d got read=%0d irq=%0b want read=0 irq=0", i, read, irq);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] c;
    logic [7:0] s;
    for (int i = 0; i < 400; i++) begin
      c = 8'($urandom_range(0, 255));
      c[1] = ($urandom_range(0, 15) == 0);
      c[0] = ($urandom_range(0, 7) != 0);
      c[6:4] = 3'($urandom_range(0, 1));
      s = 8'($urandom_range(0, 6));
      step(c, s);
      total++;
      if (read !== m_count || irq !== m_irq) begin
        bad++;
        $display("FAIL random step=%0d ctrl=%02h got read=%0d irq=%0b want read=%0d irq=%0b",
                 i, c, read, irq, m_count, m_irq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_reload(1'b1);
    test_reload(1'b0);
    test_prescaler();
    test_load_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
